logicnets_input_stage: RTL and testbench
========================================

LOGICNETS_INPUT_STAGE -- requirements
Module: logicnets_input_stage

Interface
REQ-001 SHALL have parameter N_FEAT, default 8: number of features per frame.
REQ-002 SHALL have parameter IN_W, default 16: signed feature width.
REQ-003 SHALL have parameter QBITS, fixed at 2: quantized code width per feature.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port s_valid, input, 1 bit: feature word valid.
REQ-007 SHALL have port s_ready, output, 1 bit: stage can accept a feature.
REQ-008 SHALL have port s_data, input, IN_W bits: signed feature sample.
REQ-009 SHALL have port s_last, input, 1 bit: marks the final feature of a frame.
REQ-010 SHALL have port m_valid, output, 1 bit: quantized frame valid to the layer-0 LUT array.
REQ-011 SHALL have port m_ready, input, 1 bit: LUT array/pipeline accepts the frame.
REQ-012 SHALL have port m_data, output, N_FEAT*QBITS bits: packed codes; feature i in bits [2i+1:2i].
REQ-013 SHALL have port frame_err, output, 1 bit: sticky framing-error flag.
REQ-014 SHALL have port err_clr, input, 1 bit: clears frame_err.

Function
REQ-015 SHALL accept a feature on any cycle where s_valid and s_ready are both 1.
REQ-016 SHALL quantize each feature i to code = count of per-feature thresholds T0[i]<T1[i]<T2[i] satisfying s_data >= Tk[i], using a signed compare, giving a code of 0..3.
REQ-017 SHALL write accepted feature k into the assembly buffer slot k, where k is a feature counter of width clog2(N_FEAT) that starts at 0.
REQ-018 SHALL, on acceptance with k = N_FEAT-1 and s_last = 1, mark the assembly buffer complete and reset k to 0.
REQ-019 SHALL, on acceptance with s_last mismatched (s_last=1 with k<N_FEAT-1, or s_last=0 with k=N_FEAT-1), discard the partial frame, reset k to 0, and set frame_err; that word is dropped.
REQ-020 SHALL run an assembly state machine with two states: FILL (collecting features) and HELD (buffer complete, output register occupied).
REQ-021 SHALL move a complete buffer into the output register on the same edge it completes if the output register is empty or is being consumed (m_valid and m_ready) that cycle, and stay in FILL.
REQ-022 SHALL otherwise enter HELD and transfer the buffer on the first cycle the output register frees.
REQ-023 SHALL hold s_ready = 0 only in HELD; s_ready SHALL NOT depend combinationally on s_valid.
REQ-024 SHALL assert m_valid one cycle after the last feature of a frame is accepted when the output register is free (latency 1).
REQ-025 SHALL keep m_data stable while m_valid = 1 and m_ready = 0.
REQ-026 SHALL support back-to-back frames at one feature per cycle with no bubble when m_ready is held at 1.
REQ-027 SHALL give err_clr priority below a same-cycle framing error: frame_err remains 1.

Reset
REQ-028 SHALL drive, while rst_n = 0: s_ready=0, m_valid=0, m_data=0, frame_err=0, k=0, state=FILL, assembly buffer cleared.
REQ-029 SHALL assert s_ready=1 on the first edge after rst_n deasserts.
REQ-030 SHALL discard, on reset asserted mid-frame or mid-hold, all partial and held data with no output.

Structure
REQ-031 SHALL define the shared package logicnets_pkg to hold N_FEAT, IN_W, QBITS, the threshold arrays T0/T1/T2 indexed by feature, and a typedef for a code.
REQ-032 SHALL implement the threshold compare as one sub-module, feat_quantizer (combinational: data and feature index in, 2-bit code out), instantiated once.

Verification
REQ-033 Bench SHALL cover: with T=(-100,0,100) for all features, a frame of values -200, -100, -1, 0, 99, 100, 32767, -32768 with m_ready=1 -> m_data = codes 0,1,1,2,2,3,3,0 and m_valid 1 cycle after the 8th accept.
REQ-034 Bench SHALL cover: m_ready=0 across 3 full frames -> frame 1 held on output, frame 2 held in HELD, s_ready=0; m_ready=1 -> frames 1 and 2 drain in order and s_ready returns to 1.
REQ-035 Bench SHALL cover: s_last=1 on the 5th feature -> frame_err=1, no m_valid; the next correct 8-word frame is output correctly.
REQ-036 Bench SHALL cover: s_last=0 on the 8th feature -> frame_err=1 and the frame is dropped; err_clr pulse -> frame_err=0.
REQ-037 Bench SHALL cover: rst_n low after 4 features -> all outputs return to reset values; the following full frame is output with no stale codes.
REQ-038 Bench SHALL cover: continuous s_valid=1 and m_ready=1 over 16 frames -> one m_valid every 8 cycles, with s_ready never 0.

Source files
------------

// File: rtl/logicnets_pkg.sv
// Shared definitions for the LogicNets input stage.
// Holds frame geometry (N_FEAT, IN_W, QBITS), the per-feature quantization
// thresholds T0 < T1 < T2, the quantized code type and the assembly FSM states.
package logicnets_pkg;

    localparam int unsigned N_FEAT = 8;
    localparam int unsigned IN_W   = 16;
    localparam int unsigned QBITS  = 2;
    localparam int unsigned K_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;

    typedef logic [QBITS-1:0] code_t;

    // Entry i is the threshold for feature i; values are signed IN_W-bit.
    typedef logic [N_FEAT-1:0][IN_W-1:0] thr_arr_t;

    localparam thr_arr_t T0 = {N_FEAT{IN_W'(-100)}};
    localparam thr_arr_t T1 = {N_FEAT{IN_W'(0)}};
    localparam thr_arr_t T2 = {N_FEAT{IN_W'(100)}};

    typedef enum logic {
        StFill = 1'b0,
        StHeld = 1'b1
    } state_t;

endpackage

// File: rtl/feat_quantizer.sv
// Combinational per-feature quantizer.
// Ports:
//   i_data - signed feature sample
//   i_idx  - feature index selecting the threshold set
//   o_code - number of thresholds T0/T1/T2 that i_data meets or exceeds (0..3)
module feat_quantizer
    import logicnets_pkg::*;
(
    input  logic [IN_W-1:0] i_data,
    input  logic [K_W-1:0]  i_idx,
    output code_t           o_code
);

    logic signed [IN_W-1:0] w_x;
    logic signed [IN_W-1:0] w_t0;
    logic signed [IN_W-1:0] w_t1;
    logic signed [IN_W-1:0] w_t2;

    assign w_x  = $signed(i_data);
    assign w_t0 = $signed(T0[i_idx]);
    assign w_t1 = $signed(T1[i_idx]);
    assign w_t2 = $signed(T2[i_idx]);

    always_comb begin
        o_code = '0;
        if (w_x >= w_t0) o_code = o_code + 2'd1;
        if (w_x >= w_t1) o_code = o_code + 2'd1;
        if (w_x >= w_t2) o_code = o_code + 2'd1;
    end

endmodule

// File: rtl/logicnets_input_stage.sv
// LogicNets input stage: quantizes a stream of signed features into 2-bit codes,
// assembles N_FEAT codes into a frame and hands whole frames to the layer-0 LUTs.
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready     - feature stream handshake; s_data sample, s_last frame end
//   m_valid/m_ready     - frame handshake; m_data packed codes, feature i at [2i+1:2i]
//   frame_err, err_clr  - sticky framing error flag and its clear
module logicnets_input_stage
    import logicnets_pkg::*;
#(
    parameter int unsigned N_FEAT = logicnets_pkg::N_FEAT,
    parameter int unsigned IN_W   = logicnets_pkg::IN_W,
    parameter int unsigned QBITS  = logicnets_pkg::QBITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [IN_W-1:0]         s_data,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [N_FEAT*QBITS-1:0] m_data,
    output logic                    frame_err,
    input  logic                    err_clr
);

    localparam int unsigned KW = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_FEAT - 1);

    state_t                  r_state;
    state_t                  w_state_d;
    logic [KW-1:0]           r_k;
    logic [KW-1:0]           w_k_d;
    logic [N_FEAT*QBITS-1:0] r_buf;
    logic [N_FEAT*QBITS-1:0] w_buf_d;
    logic [N_FEAT*QBITS-1:0] r_out;
    logic [N_FEAT*QBITS-1:0] w_out_d;
    logic                    r_mvalid;
    logic                    w_mvalid_d;
    logic                    r_err;
    logic                    w_err_d;
    logic                    r_up;

    code_t w_code;
    logic  w_accept;
    logic  w_mismatch;
    logic  w_out_free;

    feat_quantizer u_quant (
        .i_data (s_data),
        .i_idx  (r_k),
        .o_code (w_code)
    );

    // r_up keeps s_ready low until the first edge after reset release.
    assign s_ready    = r_up & (r_state == StFill);
    assign w_accept   = s_valid & s_ready;
    assign w_mismatch = s_last ^ (r_k == K_LAST);
    // Output register can take a new frame if empty or drained this cycle.
    assign w_out_free = ~r_mvalid | m_ready;

    assign m_valid   = r_mvalid;
    assign m_data    = r_out;
    assign frame_err = r_err;

    always_comb begin
        w_state_d  = r_state;
        w_k_d      = r_k;
        w_buf_d    = r_buf;
        w_out_d    = r_out;
        w_mvalid_d = r_mvalid & ~m_ready;
        // A same-cycle framing error below overrides this clear.
        w_err_d    = r_err & ~err_clr;

        unique case (r_state)
            StFill: begin
                if (w_accept) begin
                    if (w_mismatch) begin
                        // Drop the offending word and everything gathered so far.
                        w_k_d   = '0;
                        w_buf_d = '0;
                        w_err_d = 1'b1;
                    end else begin
                        w_buf_d[r_k*QBITS +: QBITS] = QBITS'(w_code);
                        if (s_last) begin
                            w_k_d = '0;
                            if (w_out_free) begin
                                w_out_d    = w_buf_d;
                                w_mvalid_d = 1'b1;
                            end else begin
                                w_state_d = StHeld;
                            end
                        end else begin
                            w_k_d = r_k + 1'b1;
                        end
                    end
                end
            end
            StHeld: begin
                if (w_out_free) begin
                    w_out_d    = r_buf;
                    w_mvalid_d = 1'b1;
                    w_state_d  = StFill;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StFill;
            r_k      <= '0;
            r_buf    <= '0;
            r_out    <= '0;
            r_mvalid <= 1'b0;
            r_err    <= 1'b0;
            r_up     <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_k      <= w_k_d;
            r_buf    <= w_buf_d;
            r_out    <= w_out_d;
            r_mvalid <= w_mvalid_d;
            r_err    <= w_err_d;
            r_up     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_logicnets_input_stage.sv
// Directed self-checking bench for logicnets_input_stage.
// Thresholds are (-100, 0, 100) for every feature.
module tb_logicnets_input_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        frame_err;
    logic        err_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logicnets_input_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .frame_err (frame_err),
        .err_clr   (err_clr)
    );

    // Presents one word from a negedge and returns right after the accepting posedge.
    task automatic drive_word(input logic [15:0] d, input logic l);
        int n;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        while (s_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (s_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout: s_ready=%b required 1", s_ready);
        end
        @(posedge clk);
    endtask

    task automatic send_const(input logic [15:0] v);
        for (int i = 0; i < 8; i++) drive_word(v, (i == 7));
    endtask

    task automatic send_frame(input logic [7:0][15:0] v);
        for (int i = 0; i < 8; i++) drive_word(v[i], (i == 7));
    endtask

    task automatic go_idle();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        m_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 16'h0000) begin errors++; $display("FAIL rst_m_data: got %h want 0000", m_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
        rst_n = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_pre_edge: got %b want 0", s_ready); end
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_post_edge: got %b want 1", s_ready); end
    endtask

    task automatic test_basic();
        logic [7:0][15:0] fa;
        fa[0] = 16'hFF38; fa[1] = 16'hFF9C; fa[2] = 16'hFFFF; fa[3] = 16'h0000;
        fa[4] = 16'd99;   fa[5] = 16'd100;  fa[6] = 16'h7FFF; fa[7] = 16'h8000;
        m_ready = 1'b1;
        for (int i = 0; i < 7; i++) drive_word(fa[i], 1'b0);
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", m_valid); end
        drive_word(fa[7], 1'b1);
        go_idle();
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", m_valid); end
        checks++; if (m_data !== 16'h3E94) begin errors++; $display("FAIL basic_data: got %h want 3e94", m_data); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", m_valid); end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        send_const(16'd200);
        go_idle();
        checks++; if (m_valid !== 1'b1 || m_data !== 16'hFFFF) begin errors++; $display("FAIL bp_first: valid %b data %h want 1 ffff", m_valid, m_data); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_fill: got %b want 1", s_ready); end
        send_const(16'd50);
        go_idle();
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_held_ready: got %b want 0", s_ready); end
        checks++; if (m_valid !== 1'b1 || m_data !== 16'hFFFF) begin errors++; $display("FAIL bp_stable: valid %b data %h want 1 ffff", m_valid, m_data); end
        // Third frame is offered but must not be taken while held.
        s_valid = 1'b1; s_data = 16'hFFCE;
        repeat (3) @(negedge clk);
        checks++; if (s_ready !== 1'b0 || m_data !== 16'hFFFF) begin errors++; $display("FAIL bp_third_blocked: ready %b data %h want 0 ffff", s_ready, m_data); end
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        checks++; if (m_valid !== 1'b1 || m_data !== 16'hAAAA) begin errors++; $display("FAIL bp_second: valid %b data %h want 1 aaaa", m_valid, m_data); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b want 1", s_ready); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", m_valid); end
        send_const(16'hFFCE);
        go_idle();
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h5555) begin errors++; $display("FAIL bp_third: valid %b data %h want 1 5555", m_valid, m_data); end
    endtask

    task automatic test_early_last();
        logic [7:0][15:0] fe;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) drive_word(16'hFF6A, 1'b0);
        drive_word(16'hFF6A, 1'b1);
        go_idle();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL early_err: got %b want 1", frame_err); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL early_no_valid: got %b want 0", m_valid); end
        for (int i = 0; i < 8; i++) fe[i] = (i % 2 == 0) ? 16'hFF6A : 16'd150;
        send_frame(fe);
        go_idle();
        checks++; if (m_valid !== 1'b1 || m_data !== 16'hCCCC) begin errors++; $display("FAIL early_next: valid %b data %h want 1 cccc", m_valid, m_data); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL early_sticky: got %b want 1", frame_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL early_clr: got %b want 0", frame_err); end
    endtask

    task automatic test_late_last();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) drive_word(16'd50, 1'b0);
        go_idle();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL late_err: got %b want 1", frame_err); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL late_no_valid: got %b want 0", m_valid); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL late_no_valid2: got %b want 0", m_valid); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL late_clr: got %b want 0", frame_err); end
        // Clear and a new framing error on the same edge: the error wins.
        err_clr = 1'b1;
        drive_word(16'h0000, 1'b1);
        go_idle();
        err_clr = 1'b0;
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL late_prio: got %b want 1", frame_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL late_clr2: got %b want 0", frame_err); end
        send_const(16'hFFCE);
        go_idle();
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h5555) begin errors++; $display("FAIL late_next: valid %b data %h want 1 5555", m_valid, m_data); end
    endtask

    task automatic test_reset_mid();
        logic [7:0][15:0] fr;
        m_ready = 1'b1;
        drive_word(16'h0000, 1'b1);
        m_ready = 1'b0;
        send_const(16'd200);
        for (int i = 0; i < 4; i++) drive_word(16'd200, 1'b0);
        go_idle();
        checks++; if (m_valid !== 1'b1 || frame_err !== 1'b1) begin errors++; $display("FAIL rmid_pre: valid %b err %b want 1 1", m_valid, frame_err); end
        rst_n = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rmid_s_ready: got %b want 0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_m_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 16'h0000) begin errors++; $display("FAIL rmid_m_data: got %h want 0000", m_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rmid_frame_err: got %b want 0", frame_err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL rmid_release: ready %b valid %b want 1 0", s_ready, m_valid); end
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) fr[i] = (i < 4) ? 16'hFF9B : 16'd200;
        send_frame(fr);
        go_idle();
        checks++; if (m_valid !== 1'b1 || m_data !== 16'hFF00) begin errors++; $display("FAIL rmid_next: valid %b data %h want 1 ff00", m_valid, m_data); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [4];
        logic [15:0] exps [4];
        int pulses;
        vals[0] = 16'hFF9B; vals[1] = 16'hFFCE; vals[2] = 16'h0032; vals[3] = 16'h0065;
        exps[0] = 16'h0000; exps[1] = 16'h5555; exps[2] = 16'hAAAA; exps[3] = 16'hFFFF;
        pulses = 0;
        m_ready = 1'b1;
        for (int j = 0; j < 128; j++) begin
            @(negedge clk);
            if (j > 0) begin
                checks++;
                if (m_valid !== ((j - 1) % 8 == 7)) begin
                    errors++;
                    $display("FAIL b2b_valid beat %0d: got %b want %b", j, m_valid, ((j - 1) % 8 == 7));
                end
                if (m_valid === 1'b1) begin
                    pulses++;
                    checks++;
                    if (m_data !== exps[((j - 1) / 8) % 4]) begin
                        errors++;
                        $display("FAIL b2b_data beat %0d: got %h want %h", j, m_data, exps[((j - 1) / 8) % 4]);
                    end
                end
            end
            checks++;
            if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready beat %0d: got %b want 1", j, s_ready); end
            s_valid = 1'b1;
            s_data  = vals[(j / 8) % 4];
            s_last  = (j % 8 == 7);
            @(posedge clk);
        end
        go_idle();
        if (m_valid === 1'b1) pulses++;
        checks++; if (m_valid !== 1'b1 || m_data !== 16'hFFFF) begin errors++; $display("FAIL b2b_last: valid %b data %h want 1 ffff", m_valid, m_data); end
        checks++; if (pulses != 16) begin errors++; $display("FAIL b2b_pulses: got %0d want 16", pulses); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_early_last();
        test_late_last();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
